rle_decode: RTL and testbench

Run-length decoder for the compression datapath. On `start` it reads a packed (byte, count) stream from the shared dual-port SRAM, expands each pair into `count` copies of `byte`, and writes the plaintext back to SRAM as packed 32-bit words. It reverses the stream produced by the RLE encoder and uses the same SRAM port A protocol.

---
 rtl/rle_pkg.sv | 29 ++
 rtl/rle_word_packer.sv | 52 +++++
 rtl/rle_decode.sv | 235 +++++++++++++++++++++++
 tb/tb_rle_decode.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/rle_pkg.sv
// rle_pkg
// Shared definitions for the run-length codec: the decoder FSM state
// encoding, bit positions of the (byte, count) fields inside a compressed
// 32-bit word, and the number of bytes carried by one SRAM word.
// The encoder uses the same field constants, so the two stay in step.
package rle_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_REQ,
        ST_RD_WAIT,
        ST_EXPAND,
        ST_WR,
        ST_FLUSH,
        ST_DONE
    } rle_state_e;

    localparam int CNT0_LSB       = 0;
    localparam int BYTE0_LSB      = 8;
    localparam int CNT1_LSB       = 16;
    localparam int BYTE1_LSB      = 24;
    localparam int BYTES_PER_WORD = 4;

    // Extract one 8-bit field of a compressed word given its LSB position.
    function automatic logic [7:0] getField(input logic [31:0] word, input int lsb);
        return word[lsb +: 8];
    endfunction

endpackage

// File: rtl/rle_word_packer.sv
// rle_word_packer
// Collects plaintext bytes little-endian into a 32-bit word (first byte in
// bits [7:0]). Lanes not yet written read as 0x00, so a partially filled
// word handed out on flush is already zero-filled.
//
// Ports:
//   clk, nreset      clock, asynchronous active-low reset
//   pushByte_i       append byte_i into the next free lane
//   byte_i [7:0]     byte to append
//   flush_i          the current word is being written out; empty the packer
//   clear_i          discard contents (start of a new decode)
//   word_o [31:0]    packed word, unused lanes zero
//   lanes_o [2:0]    number of filled lanes (0..4)
//   full_o           all four lanes filled
module rle_word_packer
    import rle_pkg::*;
(
    input  logic        clk,
    input  logic        nreset,
    input  logic        pushByte_i,
    input  logic [7:0]  byte_i,
    input  logic        flush_i,
    input  logic        clear_i,
    output logic [31:0] word_o,
    output logic [2:0]  lanes_o,
    output logic        full_o
);

    logic [31:0] word_q;
    logic [2:0]  lanes_q;

    assign full_o = (lanes_q == 3'(BYTES_PER_WORD));

    // Emptying always rewrites the whole word to zero, which is what gives
    // the zero-filled upper lanes on a partial final word.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            word_q  <= '0;
            lanes_q <= '0;
        end else if (flush_i || clear_i) begin
            word_q  <= '0;
            lanes_q <= '0;
        end else if (pushByte_i && !full_o) begin
            word_q[{lanes_q[1:0], 3'b000} +: 8] <= byte_i;
            lanes_q                             <= lanes_q + 3'd1;
        end
    end

    assign word_o  = word_q;
    assign lanes_o = lanes_q;

endmodule

// File: rtl/rle_decode.sv
// rle_decode
// Run-length decoder. On start it reads packed (byte, count) pairs from the
// shared SRAM (port A), expands each pair into count copies of byte, and
// writes the plaintext back as little-endian packed 32-bit words.
//
// Ports:
//   clk, nreset          clock, asynchronous active-low reset
//   start                launch a decode (sampled in IDLE and DONE only)
//   rle_addr, rle_size   compressed stream byte address / length in bytes
//   message_addr         plaintext destination byte address
//   message_max          plaintext capacity (bounded build only)
//   message_size         plaintext bytes produced
//   done                 decode finished, held until the next start
//   overflow             output truncated at message_max
//   port_A_*             SRAM port A (1-cycle read latency, we=1 writes)
//
// Build option: define RLE_DECODE_BOUNDS_EN to stop output at message_max
// bytes and flag overflow; otherwise message_max is ignored and overflow is 0.
module rle_decode
    import rle_pkg::*;
(
    input  logic        clk,
    input  logic        nreset,
    input  logic        start,
    input  logic [31:0] rle_addr,
    input  logic [31:0] rle_size,
    input  logic [31:0] message_addr,
    input  logic [31:0] message_max,
    output logic [31:0] message_size,
    output logic        done,
    output logic        overflow,
    output logic        port_A_clk,
    output logic [15:0] port_A_addr,
    output logic [31:0] port_A_data_in,
    input  logic [31:0] port_A_data_out,
    output logic        port_A_we
);

    rle_state_e  state_q, state_d;
    logic [31:0] rdPtr_q, rdPtr_d;
    logic [31:0] wrPtr_q, wrPtr_d;
    logic [31:0] rdLeft_q, rdLeft_d;
    logic [31:0] word_q, word_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        pairIdx_q, pairIdx_d;
    logic        twoPairs_q, twoPairs_d;
    logic        wordDone_q, wordDone_d;
    logic [31:0] msgSize_q, msgSize_d;

    logic        pushByte, packFlush, packClear;
    logic [7:0]  curByte;
    logic        lastPair;
    logic        startAccept;
    logic        boundHit;
    logic [31:0] packWord;
    logic [2:0]  packLanes;
    logic        packFull;

    rle_word_packer u_packer (
        .clk        (clk),
        .nreset     (nreset),
        .pushByte_i (pushByte),
        .byte_i     (curByte),
        .flush_i    (packFlush),
        .clear_i    (packClear),
        .word_o     (packWord),
        .lanes_o    (packLanes),
        .full_o     (packFull)
    );

    assign port_A_clk   = clk;
    assign done         = (state_q == ST_DONE);
    assign message_size = msgSize_q;
    assign startAccept  = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    assign curByte      = getField(word_q, pairIdx_q ? BYTE1_LSB : BYTE0_LSB);
    assign lastPair     = pairIdx_q || !twoPairs_q;

`ifdef RLE_DECODE_BOUNDS_EN
    logic overflow_q;

    // Stop before emitting a byte that would go past the buffer. The size
    // counter has reached message_max at this point, so it is left as is.
    assign boundHit = (cnt_q != 8'd0) && (msgSize_q >= message_max);

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset)
            overflow_q <= 1'b0;
        else if (startAccept)
            overflow_q <= 1'b0;
        else if ((state_q == ST_EXPAND) && boundHit)
            overflow_q <= 1'b1;
    end

    assign overflow = overflow_q;
`else
    logic unused_message_max;

    assign unused_message_max = ^message_max;
    assign boundHit           = 1'b0;
    assign overflow           = 1'b0;
`endif

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q    <= ST_IDLE;
            rdPtr_q    <= '0;
            wrPtr_q    <= '0;
            rdLeft_q   <= '0;
            word_q     <= '0;
            cnt_q      <= '0;
            pairIdx_q  <= 1'b0;
            twoPairs_q <= 1'b0;
            wordDone_q <= 1'b0;
            msgSize_q  <= '0;
        end else begin
            state_q    <= state_d;
            rdPtr_q    <= rdPtr_d;
            wrPtr_q    <= wrPtr_d;
            rdLeft_q   <= rdLeft_d;
            word_q     <= word_d;
            cnt_q      <= cnt_d;
            pairIdx_q  <= pairIdx_d;
            twoPairs_q <= twoPairs_d;
            wordDone_q <= wordDone_d;
            msgSize_q  <= msgSize_d;
        end
    end

    // cnt_q is the number of copies still owed for the current pair. A pair
    // ends on its last byte, or immediately (one idle cycle) when its count
    // is zero; the next pair's count is loaded in that same cycle.
    always_comb begin
        state_d        = state_q;
        rdPtr_d        = rdPtr_q;
        wrPtr_d        = wrPtr_q;
        rdLeft_d       = rdLeft_q;
        word_d         = word_q;
        cnt_d          = cnt_q;
        pairIdx_d      = pairIdx_q;
        twoPairs_d     = twoPairs_q;
        wordDone_d     = wordDone_q;
        msgSize_d      = msgSize_q;
        pushByte       = 1'b0;
        packFlush      = 1'b0;
        packClear      = 1'b0;
        port_A_we      = 1'b0;
        port_A_addr    = '0;
        port_A_data_in = '0;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    rdPtr_d   = rle_addr;
                    wrPtr_d   = message_addr;
                    rdLeft_d  = rle_size;
                    msgSize_d = '0;
                    packClear = 1'b1;
                    state_d   = (rle_size == 32'd0) ? ST_FLUSH : ST_RD_REQ;
                end
            end
            ST_RD_REQ: begin
                port_A_addr = rdPtr_q[15:0];
                state_d     = ST_RD_WAIT;
            end
            ST_RD_WAIT: begin
                word_d     = port_A_data_out;
                rdPtr_d    = rdPtr_q + 32'(BYTES_PER_WORD);
                cnt_d      = getField(port_A_data_out, CNT0_LSB);
                pairIdx_d  = 1'b0;
                wordDone_d = 1'b0;
                // A trailing 2-byte remainder carries only pair 0.
                if (rdLeft_q >= 32'(BYTES_PER_WORD)) begin
                    twoPairs_d = 1'b1;
                    rdLeft_d   = rdLeft_q - 32'(BYTES_PER_WORD);
                end else begin
                    twoPairs_d = 1'b0;
                    rdLeft_d   = '0;
                end
                state_d = ST_EXPAND;
            end
            ST_EXPAND: begin
                if (boundHit) begin
                    state_d = ST_FLUSH;
                end else begin
                    if (cnt_q != 8'd0) begin
                        pushByte  = 1'b1;
                        msgSize_d = msgSize_q + 32'd1;
                    end
                    if (cnt_q <= 8'd1) begin
                        if (lastPair) begin
                            wordDone_d = 1'b1;
                            cnt_d      = 8'd0;
                        end else begin
                            pairIdx_d = 1'b1;
                            cnt_d     = getField(word_q, CNT1_LSB);
                        end
                    end else begin
                        cnt_d = cnt_q - 8'd1;
                    end
                    if ((cnt_q != 8'd0) && (packLanes == 3'(BYTES_PER_WORD - 1)))
                        state_d = ST_WR;
                    else if ((cnt_q <= 8'd1) && lastPair)
                        state_d = (rdLeft_q == 32'd0) ? ST_FLUSH : ST_RD_REQ;
                end
            end
            ST_WR: begin
                port_A_we      = 1'b1;
                port_A_addr    = wrPtr_q[15:0];
                port_A_data_in = packWord;
                packFlush      = 1'b1;
                wrPtr_d        = wrPtr_q + 32'(BYTES_PER_WORD);
                // Going straight to DONE when the input is used up keeps done
                // one cycle after the last write.
                if (!wordDone_q)
                    state_d = ST_EXPAND;
                else if (rdLeft_q == 32'd0)
                    state_d = ST_DONE;
                else
                    state_d = ST_RD_REQ;
            end
            ST_FLUSH: begin
                if (packLanes != 3'd0) begin
                    port_A_we      = 1'b1;
                    port_A_addr    = wrPtr_q[15:0];
                    port_A_data_in = packWord;
                    packFlush      = 1'b1;
                    wrPtr_d        = wrPtr_q + 32'(BYTES_PER_WORD);
                end
                state_d = ST_DONE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_rle_decode.sv
// tb_rle_decode
// Directed bench for rle_decode with a small 1-cycle-latency SRAM model.
// Expected plaintext words, sizes and cycle counts are worked out by hand.
module tb_rle_decode;

    logic        clk = 1'b0;
    logic        nreset = 1'b0;
    logic        start = 1'b0;
    logic [31:0] rleAddr = '0;
    logic [31:0] rleSize = '0;
    logic [31:0] messageAddr = '0;
    logic [31:0] messageMax = '0;
    logic [31:0] messageSize;
    logic        done;
    logic        overflow;
    logic        portAClk;
    logic [15:0] portAAddr;
    logic [31:0] portADataIn;
    logic [31:0] portADataOut;
    logic        portAWe;

    int totalChecks = 0;
    int badChecks = 0;
    int cycles;

    logic [31:0] mem [0:16383];
    logic [15:0] sampAddr = '0;
    logic        sampWe = 1'b0;
    logic [31:0] sampData = '0;
    logic [31:0] readData = '0;
    logic        loadEn = 1'b0;
    logic [13:0] loadIdx = '0;
    logic [31:0] loadData = '0;
    logic [31:0] wrAddrQ [$];
    logic [31:0] wrDataQ [$];

    always #5 clk = ~clk;

    assign portADataOut = readData;

    rle_decode dut (
        .clk             (clk),
        .nreset          (nreset),
        .start           (start),
        .rle_addr        (rleAddr),
        .rle_size        (rleSize),
        .message_addr    (messageAddr),
        .message_max     (messageMax),
        .message_size    (messageSize),
        .done            (done),
        .overflow        (overflow),
        .port_A_clk      (portAClk),
        .port_A_addr     (portAAddr),
        .port_A_data_in  (portADataIn),
        .port_A_data_out (portADataOut),
        .port_A_we       (portAWe)
    );

    // Capture the port mid-cycle so the SRAM acts on stable values at the
    // following rising edge; every write the DUT issues is logged here.
    always @(negedge clk) begin
        sampAddr = portAAddr;
        sampWe   = portAWe;
        sampData = portADataIn;
        if (portAWe) begin
            wrAddrQ.push_back({16'h0000, portAAddr});
            wrDataQ.push_back(portADataIn);
        end
    end

    // SRAM: registered read (1-cycle latency), write on the rising edge,
    // plus a preload path used by the bench to place compressed words.
    always @(posedge clk) begin
        if (loadEn)
            mem[loadIdx] <= loadData;
        else if (sampWe)
            mem[sampAddr[15:2]] <= sampData;
        else
            readData <= mem[sampAddr[15:2]];
    end

    // Single comparison point: counts every check, reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        totalChecks++;
        if (observed !== expected) begin
            badChecks++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic loadWord(input logic [31:0] addr, input logic [31:0] data);
        @(negedge clk);
        loadEn   = 1'b1;
        loadIdx  = addr[15:2];
        loadData = data;
        @(negedge clk);
        loadEn = 1'b0;
    endtask

    // Launch one decode and wait (bounded) for done; cycles counts rising
    // edges from the one that accepts start up to the one that raises done.
    task automatic applyStimulus(input logic [31:0] rAddr, input logic [31:0] rSize,
                                 input logic [31:0] mAddr, input logic [31:0] mMax,
                                 output int nCycles);
        wrAddrQ.delete();
        wrDataQ.delete();
        @(negedge clk);
        rleAddr     = rAddr;
        rleSize     = rSize;
        messageAddr = mAddr;
        messageMax  = mMax;
        start       = 1'b1;
        nCycles     = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            start = 1'b0;
            nCycles++;
            if (done) break;
        end
        checkOutput("done reached", {31'd0, done}, 32'd1);
    endtask

    // Expected result of the basic stimulus word 0x42024103 (3 x 0x41, 2 x 0x42).
    task automatic checkBasic(input string tag, input int nCycles);
        checkOutput({tag, " write count"}, wrAddrQ.size(), 32'd2);
        if (wrAddrQ.size() == 2) begin
            checkOutput({tag, " addr0"}, wrAddrQ[0], 32'h0000_0200);
            checkOutput({tag, " data0"}, wrDataQ[0], 32'h4241_4141);
            checkOutput({tag, " addr1"}, wrAddrQ[1], 32'h0000_0204);
            checkOutput({tag, " data1"}, wrDataQ[1], 32'h0000_0042);
        end
        checkOutput({tag, " message_size"}, messageSize, 32'd5);
        checkOutput({tag, " overflow"}, {31'd0, overflow}, 32'd0);
        checkOutput({tag, " cycles"}, nCycles, 32'd10);
    endtask

    initial begin
        int badWords;

        // Reset values while nreset is held low.
        repeat (2) @(negedge clk);
        checkOutput("reset done", {31'd0, done}, 32'd0);
        checkOutput("reset overflow", {31'd0, overflow}, 32'd0);
        checkOutput("reset we", {31'd0, portAWe}, 32'd0);
        checkOutput("reset addr", {16'd0, portAAddr}, 32'd0);
        checkOutput("reset data_in", portADataIn, 32'd0);
        checkOutput("reset message_size", messageSize, 32'd0);

        loadWord(32'h0100, 32'h4202_4103);
        loadWord(32'h0300, 32'h0000_FFFF);
        loadWord(32'h0500, 32'h5501_0000);
        @(negedge clk);
        nreset = 1'b1;

        // Basic expansion.
        applyStimulus(32'h0100, 32'd4, 32'h0200, 32'd4096, cycles);
        checkBasic("basic", cycles);

        // Maximum count: 255 copies of 0xFF, upper pair ignored.
        applyStimulus(32'h0300, 32'd2, 32'h0400, 32'd4096, cycles);
        checkOutput("max write count", wrAddrQ.size(), 32'd64);
        badWords = 0;
        foreach (wrAddrQ[i]) begin
            if (wrAddrQ[i] !== 32'h0400 + 32'(4 * i)) badWords++;
            if (i < 63 && wrDataQ[i] !== 32'hFFFF_FFFF) badWords++;
        end
        checkOutput("max word errors", badWords, 32'd0);
        if (wrDataQ.size() == 64)
            checkOutput("max last word", wrDataQ[63], 32'h00FF_FFFF);
        checkOutput("max message_size", messageSize, 32'd255);
        checkOutput("max cycles", cycles, 32'd322);

        // Zero-count pair followed by a single 0x55.
        applyStimulus(32'h0500, 32'd4, 32'h0600, 32'd4096, cycles);
        checkOutput("zero write count", wrAddrQ.size(), 32'd1);
        if (wrDataQ.size() == 1) begin
            checkOutput("zero addr", wrAddrQ[0], 32'h0000_0600);
            checkOutput("zero data", wrDataQ[0], 32'h0000_0055);
        end
        checkOutput("zero message_size", messageSize, 32'd1);
        checkOutput("zero cycles", cycles, 32'd6);

        // Empty input.
        applyStimulus(32'h0100, 32'd0, 32'h0700, 32'd4096, cycles);
        checkOutput("empty write count", wrAddrQ.size(), 32'd0);
        checkOutput("empty within 3", {31'd0, (cycles <= 3)}, 32'd1);
        checkOutput("empty message_size", messageSize, 32'd0);

        // Reset during the expansion of the maximum-count stream.
        @(negedge clk);
        rleAddr     = 32'h0300;
        rleSize     = 32'd2;
        messageAddr = 32'h0800;
        start       = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (20) @(negedge clk);
        nreset = 1'b0;
        #1;
        checkOutput("midrst done", {31'd0, done}, 32'd0);
        checkOutput("midrst overflow", {31'd0, overflow}, 32'd0);
        checkOutput("midrst we", {31'd0, portAWe}, 32'd0);
        checkOutput("midrst addr", {16'd0, portAAddr}, 32'd0);
        checkOutput("midrst data_in", portADataIn, 32'd0);
        checkOutput("midrst message_size", messageSize, 32'd0);
        @(negedge clk);
        nreset = 1'b1;
        applyStimulus(32'h0100, 32'd4, 32'h0200, 32'd4096, cycles);
        checkBasic("after reset", cycles);

`ifdef RLE_DECODE_BOUNDS_EN
        // Bounded: only the first full word fits in 4 bytes.
        applyStimulus(32'h0100, 32'd4, 32'h0200, 32'd4, cycles);
        checkOutput("bounds write count", wrAddrQ.size(), 32'd1);
        if (wrDataQ.size() == 1)
            checkOutput("bounds data", wrDataQ[0], 32'h4241_4141);
        checkOutput("bounds overflow", {31'd0, overflow}, 32'd1);
        checkOutput("bounds message_size", messageSize, 32'd4);
`else
        // Unbounded build ignores a small message_max.
        applyStimulus(32'h0100, 32'd4, 32'h0200, 32'd2, cycles);
        checkBasic("ignored max", cycles);
`endif

        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end

endmodule
